fp_align_prep: RTL and testbench
================================

// Module: fp_align_prep
// PURPOSE
//  Operand-prep stage directly upstream of the FP32/FP16 alignment barrel shifter in the
//  shared FP add path. Unpacks two operands, compares magnitudes, swaps so the larger is
//  "big", and produces the shifter inputs S (saturated exponent difference) and X (smaller
//  significand, hidden bit at bit 25). 2-stage valid/ready pipeline.
// PARAMETERS
//  SHIFT_SAT  26  max value driven on out_s (shifter width; larger diffs clamp here)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   input beat valid
//  in_ready     out  1   stage can accept a beat
//  in_fmt       in   1   0: FP32, 1: FP16 (operand in bits [15:0], [31:16] ignored)
//  in_a, in_b   in   32  operands
//  in_sub       in   1   1: a-b, 0: a+b
//  out_valid    out  1   output beat valid
//  out_ready    in   1   downstream (shifter stage) accepts
//  out_fmt      out  1   registered fmt, drives shifter fmt
//  out_s        out  8   shift amount, min(|ea-eb|, SHIFT_SAT)
//  out_x        out  26  smaller significand, left-justified, hidden bit at [25]
//  out_big      out  26  larger significand, same alignment
//  out_exp      out  8   larger biased exponent (FP16: zero-extended 5 bits)
//  out_sign     out  1   result sign before normalisation (sign of big, b sign xor in_sub)
//  out_eff_sub  out  1   effective subtraction (sign_a != sign_b')
//  out_special  out  1   either operand NaN/Inf; out_s forced 0
//  out_sticky   out  1   OR of out_x bits discarded by shift (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all out_* = 0, both stage valids = 0, in_ready = 1.
//  - Latency 2 cycles in_valid&in_ready -> out_valid with no backpressure; throughput 1/clk.
//  - Handshake: beat transfers on valid&ready; out_* held stable while out_valid&!out_ready.
//    Stage advance: s2 loads when !s2_v | out_ready; s1 loads when !s1_v | s2 loads;
//    in_ready = !s1_v | s2 loads (combinational from out_ready, no skid buffer).
//  - S1: unpack both (exp==0 -> hidden 0, effective exp 1); FP32 sig {h,f[22:0],2'b0},
//    FP16 sig {h,f[9:0],15'b0}; b sign inverted if in_sub; compute ea-eb, eb-ea, mag compare.
//  - S2: swap if |b|>|a| (exp then significand; equal -> no swap, sign from a);
//    diff = larger-smaller exp, out_s = diff>SHIFT_SAT ? SHIFT_SAT : diff.
//  - Special: exp all-ones on either operand -> out_special=1, out_s=0, out_x=out_big=0,
//    out_exp=all-ones; sign/eff_sub still computed.
//  - Zero operands: treated as denormal; 0+0 -> out_s=0, out_x=out_big=0, out_exp=1.
//  - Reset asserted mid-flight: all in-flight beats dropped, no partial output.
//  - Simultaneous full pipe + out_ready=1 + in_valid=1: all stages advance, no bubble.
// CONFIGURATION
//  - FP_ALIGN_STICKY_EN defined: s2 computes out_sticky = |(out_x & ((1<<out_s)-1))
//    (all bits if out_s==SHIFT_SAT), registered with the beat.
//  - Undefined: out_sticky tied 0, no mask logic synthesised.
// STRUCTURE
//  - Package fp_align_pkg: fmt_e {FMT_FP32=0, FMT_FP16=1}; SIG_W=26, EXP_W=8;
//    FP32/FP16 bias and field-width constants; unpacked_t {sign, exp, sig, is_special}.
//  - Sub-module fp_unpack (combinational, fmt + 32b -> unpacked_t), instantiated for a and b.
//  - Top holds the two pipeline registers, swap/compare and handshake logic.
// TESTING
//  - FP32 a=0x3F800000, b=0x3F000000, add -> out_s=1, out_x=out_big=26'h2000000,
//    out_exp=0x7F, out_sign=0, out_eff_sub=0, 2 cycles after accept.
//  - Swap: a=0x3F000000, b=0xBF800000, add -> out_s=1, out_exp=0x7F, out_sign=1, out_eff_sub=1.
//  - FP16 a=0x7BFF, b=0x0001 -> diff 29 clamps out_s=26, out_x=26'h0008000,
//    out_big=26'h3FF8000, out_exp=30; with FP_ALIGN_STICKY_EN out_sticky=1.
//  - Special: a=0x7FC00000, b=any -> out_special=1, out_s=0, out_exp=0xFF.
//  - Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles -> in_ready falls once
//    2 beats held, out_* stable, all 4 beats exit in order, none lost/duplicated.
//  - Reset pulse with 2 beats in flight -> out_valid=0 and in_ready=1 in the reset cycle;
//    no stale beat appears after release.

Source files
------------

// File: rtl/fp_align_pkg.sv
// Shared types and constants for the FP add operand-prep stage.
// Optional sticky generation in fp_align_prep is enabled by FP_ALIGN_STICKY_EN.
package fp_align_pkg;

  typedef enum logic {
    FMT_FP32 = 1'b0,
    FMT_FP16 = 1'b1
  } fmt_e;

  localparam int SIG_W = 26;
  localparam int EXP_W = 8;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_BIAS   = 127;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_BIAS   = 15;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_special;
  } unpacked_t;

  // Clamp an exponent difference to the shifter width.
  function automatic logic [EXP_W-1:0] sat_shift(input logic [EXP_W-1:0] diff,
                                                 input logic [EXP_W-1:0] sat);
    return (diff > sat) ? sat : diff;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one FP32/FP16 operand into sign, effective exponent,
// left-justified significand (hidden bit at [25]) and NaN/Inf flag.
module fp_unpack
  import fp_align_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [31:0] i_op,
  input  logic        i_neg,
  output unpacked_t   o_unp
);

  logic [FP32_EXP_W-1:0]  w_exp32;
  logic [FP32_FRAC_W-1:0] w_frac32;
  logic [FP16_EXP_W-1:0]  w_exp16;
  logic [FP16_FRAC_W-1:0] w_frac16;

  assign w_exp32  = i_op[30:23];
  assign w_frac32 = i_op[22:0];
  assign w_exp16  = i_op[14:10];
  assign w_frac16 = i_op[9:0];

  // Denormals and zero take effective exponent 1 with a clear hidden bit.
  always_comb begin
    o_unp = '0;
    if (i_fmt == FMT_FP16) begin
      o_unp.sign       = i_op[15] ^ i_neg;
      o_unp.exp        = (w_exp16 == '0) ? EXP_W'(1) : EXP_W'(w_exp16);
      o_unp.sig        = {(w_exp16 != '0), w_frac16, {(SIG_W-1-FP16_FRAC_W){1'b0}}};
      o_unp.is_special = &w_exp16;
    end else begin
      o_unp.sign       = i_op[31] ^ i_neg;
      o_unp.exp        = (w_exp32 == '0) ? EXP_W'(1) : EXP_W'(w_exp32);
      o_unp.sig        = {(w_exp32 != '0), w_frac32, {(SIG_W-1-FP32_FRAC_W){1'b0}}};
      o_unp.is_special = &w_exp32;
    end
  end

endmodule

// File: rtl/fp_align_prep.sv
// Two-stage valid/ready operand prep for the FP add alignment shifter: unpack and
// compare in S1, swap and saturate the shift amount in S2. Sticky: FP_ALIGN_STICKY_EN.
module fp_align_prep
  import fp_align_pkg::*;
#(
  parameter int unsigned SHIFT_SAT = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_fmt,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_fmt,
  output logic [EXP_W-1:0]  out_s,
  output logic [SIG_W-1:0]  out_x,
  output logic [SIG_W-1:0]  out_big,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_eff_sub,
  output logic              out_special,
  output logic              out_sticky
);

  localparam logic [EXP_W-1:0] SAT_AMT = EXP_W'(SHIFT_SAT);

  fmt_e      w_in_fmt;
  unpacked_t w_unp_a;
  unpacked_t w_unp_b;
  logic      w_s1_load;
  logic      w_s2_load;

  logic             r_s1_v;
  fmt_e             r_s1_fmt;
  unpacked_t        r_s1_a;
  unpacked_t        r_s1_b;
  logic [EXP_W-1:0] r_s1_dab;
  logic [EXP_W-1:0] r_s1_dba;
  logic             r_s1_b_gt_a;

  logic             r_s2_v;
  logic             r_fmt;
  logic [EXP_W-1:0] r_s;
  logic [SIG_W-1:0] r_x;
  logic [SIG_W-1:0] r_big;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic             r_eff_sub;
  logic             r_special;

  assign w_in_fmt = fmt_e'(in_fmt);

  fp_unpack u_unp_a (
    .i_fmt (w_in_fmt),
    .i_op  (in_a),
    .i_neg (1'b0),
    .o_unp (w_unp_a)
  );

  fp_unpack u_unp_b (
    .i_fmt (w_in_fmt),
    .i_op  (in_b),
    .i_neg (in_sub),
    .o_unp (w_unp_b)
  );

  // No skid buffer: readiness ripples straight back from out_ready.
  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_fmt    <= FMT_FP32;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_dab    <= '0;
      r_s1_dba    <= '0;
      r_s1_b_gt_a <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_fmt    <= w_in_fmt;
        r_s1_a      <= w_unp_a;
        r_s1_b      <= w_unp_b;
        r_s1_dab    <= w_unp_a.exp - w_unp_b.exp;
        r_s1_dba    <= w_unp_b.exp - w_unp_a.exp;
        r_s1_b_gt_a <= {w_unp_b.exp, w_unp_b.sig} > {w_unp_a.exp, w_unp_a.sig};
      end
    end
  end

  logic             w_special;
  logic [EXP_W-1:0] w_diff;
  logic [EXP_W-1:0] w_s;
  logic [SIG_W-1:0] w_x;
  logic [SIG_W-1:0] w_big;
  logic [EXP_W-1:0] w_exp;
  logic             w_sign;
  logic             w_eff_sub;
  logic [EXP_W-1:0] w_exp_ones;

  // Equal magnitudes keep a as the big operand, so the sign then follows a.
  assign w_special  = r_s1_a.is_special || r_s1_b.is_special;
  assign w_diff     = r_s1_b_gt_a ? r_s1_dba : r_s1_dab;
  assign w_exp_ones = (r_s1_fmt == FMT_FP16) ? EXP_W'({FP16_EXP_W{1'b1}}) : {EXP_W{1'b1}};
  assign w_s        = w_special ? '0 : sat_shift(w_diff, SAT_AMT);
  assign w_x        = w_special ? '0 : (r_s1_b_gt_a ? r_s1_a.sig : r_s1_b.sig);
  assign w_big      = w_special ? '0 : (r_s1_b_gt_a ? r_s1_b.sig : r_s1_a.sig);
  assign w_exp      = w_special ? w_exp_ones : (r_s1_b_gt_a ? r_s1_b.exp : r_s1_a.exp);
  assign w_sign     = r_s1_b_gt_a ? r_s1_b.sign : r_s1_a.sign;
  assign w_eff_sub  = r_s1_a.sign ^ r_s1_b.sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_fmt     <= 1'b0;
      r_s       <= '0;
      r_x       <= '0;
      r_big     <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_eff_sub <= 1'b0;
      r_special <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_fmt     <= r_s1_fmt;
        r_s       <= w_s;
        r_x       <= w_x;
        r_big     <= w_big;
        r_exp     <= w_exp;
        r_sign    <= w_sign;
        r_eff_sub <= w_eff_sub;
        r_special <= w_special;
      end
    end
  end

`ifdef FP_ALIGN_STICKY_EN
  logic [SIG_W-1:0] w_mask;
  logic             w_sticky;
  logic             r_sticky;

  // Mask of the bits the shifter will push out; a full-width shift loses everything.
  assign w_mask   = (w_s >= EXP_W'(SIG_W)) ? {SIG_W{1'b1}}
                                           : ((SIG_W'(1) << w_s) - SIG_W'(1));
  assign w_sticky = |(w_x & w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_s2_load && r_s1_v) begin
      r_sticky <= w_sticky;
    end
  end

  assign out_sticky = r_sticky;
`else
  assign out_sticky = 1'b0;
`endif

  assign out_valid   = r_s2_v;
  assign out_fmt     = r_fmt;
  assign out_s       = r_s;
  assign out_x       = r_x;
  assign out_big     = r_big;
  assign out_exp     = r_exp;
  assign out_sign    = r_sign;
  assign out_eff_sub = r_eff_sub;
  assign out_special = r_special;

endmodule

// File: tb/tb_fp_align_prep.sv
// Scoreboard bench for fp_align_prep: directed cases, backpressure, mid-flight reset
// and randomized traffic against an arithmetic reference model.
module tb_fp_align_prep;

  typedef struct {
    logic        fmt;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } beat_t;

  typedef struct {
    logic        fmt;
    logic [7:0]  s;
    logic [25:0] x;
    logic [25:0] big;
    logic [7:0]  e;
    logic        sign;
    logic        eff;
    logic        spec;
    logic        sticky;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_fmt, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_fmt;
  logic [7:0]  out_s, out_exp;
  logic [25:0] out_x, out_big;
  logic        out_sign, out_eff_sub, out_special, out_sticky;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_lat = 0;
  exp_t  sb[$];
  beat_t pend[$];
  bit    rdy_sched[$];
  bit    inrdy_hist[$];

  fp_align_prep dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
    .out_s(out_s), .out_x(out_x), .out_big(out_big), .out_exp(out_exp),
    .out_sign(out_sign), .out_eff_sub(out_eff_sub), .out_special(out_special),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference: magnitude as (effective exponent, significand) pair, plain integer arithmetic.
  function automatic exp_t model(input beat_t t);
    exp_t r;
    int fw, emax, ea, eb, eea, eeb, diff, fa, fb;
    bit sa, sbn, bgt, spec;
    longint ga, gb, ka, kb;
    fw   = t.fmt ? 10 : 23;
    emax = t.fmt ? 31 : 255;
    if (t.fmt) begin
      ea = int'(t.a[14:10]); fa = int'(t.a[9:0]);  sa  = t.a[15];
      eb = int'(t.b[14:10]); fb = int'(t.b[9:0]);  sbn = t.b[15] ^ t.sub;
    end else begin
      ea = int'(t.a[30:23]); fa = int'(t.a[22:0]); sa  = t.a[31];
      eb = int'(t.b[30:23]); fb = int'(t.b[22:0]); sbn = t.b[31] ^ t.sub;
    end
    eea = (ea == 0) ? 1 : ea;
    eeb = (eb == 0) ? 1 : eb;
    ga  = ((longint'((ea != 0) ? 1 : 0) << fw) + longint'(fa)) << (25 - fw);
    gb  = ((longint'((eb != 0) ? 1 : 0) << fw) + longint'(fb)) << (25 - fw);
    ka  = longint'(eea) * 64'd67108864 + ga;
    kb  = longint'(eeb) * 64'd67108864 + gb;
    bgt = kb > ka;
    spec = (ea == emax) || (eb == emax);
    diff = bgt ? eeb - eea : eea - eeb;
    r.fmt  = t.fmt;
    r.sign = bgt ? sbn : sa;
    r.eff  = sa != sbn;
    r.spec = spec;
    r.cyc  = 0;
    if (spec) begin
      r.s = 8'd0; r.x = 26'd0; r.big = 26'd0; r.e = 8'(emax);
    end else begin
      r.s   = 8'((diff > 26) ? 26 : diff);
      r.x   = 26'(bgt ? ga : gb);
      r.big = 26'(bgt ? gb : ga);
      r.e   = 8'(bgt ? eeb : eea);
    end
`ifdef FP_ALIGN_STICKY_EN
    r.sticky = (longint'(r.x) % (longint'(1) << r.s)) != 0;
`else
    r.sticky = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [127:0] pk_exp(input exp_t e);
    return {55'd0, e.fmt, e.s, e.x, e.big, e.e, e.sign, e.eff, e.spec, e.sticky};
  endfunction

  function automatic logic [127:0] pk_out();
    return {55'd0, out_fmt, out_s, out_x, out_big, out_exp, out_sign, out_eff_sub,
            out_special, out_sticky};
  endfunction

  // Scoreboard push on accepted input, pop/compare on accepted output, hold-stability check.
  logic [127:0] held;
  bit           hold_pend = 0;
  always @(negedge clk) begin
    exp_t e;
    beat_t t;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        t.fmt = in_fmt; t.a = in_a; t.b = in_b; t.sub = in_sub;
        e = model(t);
        e.cyc = cyc;
        sb.push_back(e);
      end
      if (hold_pend && out_valid) check("hold_stable", pk_out(), held);
      hold_pend = out_valid && !out_ready;
      held = pk_out();
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          check("beat", pk_out(), pk_exp(e));
          $display("beat fmt=%0d s=%0d x=%h big=%h exp=%h sign=%0d eff=%0d spc=%0d stk=%0d",
                   out_fmt, out_s, out_x, out_big, out_exp, out_sign, out_eff_sub,
                   out_special, out_sticky);
          if (chk_lat) check("latency", 128'(cyc - e.cyc), 128'd2);
        end
      end
    end else begin
      hold_pend = 0;
    end
  end

  task automatic add(input logic fmt, input logic [31:0] a, input logic [31:0] b,
                     input logic sub);
    beat_t t;
    t.fmt = fmt; t.a = a; t.b = b; t.sub = sub;
    pend.push_back(t);
  endtask

  task automatic run(input int in_pct, input int rdy_pct, input int budget);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
      @(posedge clk); #1;
      if (pend.size() > 0 && int'($urandom_range(99)) < in_pct) begin
        in_valid = 1'b1;
        in_fmt = pend[0].fmt; in_a = pend[0].a; in_b = pend[0].b; in_sub = pend[0].sub;
      end else begin
        in_valid = 1'b0;
        in_a = $urandom(); in_b = $urandom();
      end
      if (rdy_sched.size() > 0) out_ready = rdy_sched.pop_front();
      else out_ready = int'($urandom_range(99)) < rdy_pct;
      @(negedge clk);
      inrdy_hist.push_back(in_ready);
      if (in_valid && in_ready) void'(pend.pop_front());
      n++;
      #1;
    end
    if (n >= budget) check("run_timeout", 128'(n), 128'(budget - 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op(input logic fmt);
    logic [31:0] v;
    int k;
    v = $urandom();
    k = int'($urandom_range(9));
    if (fmt) begin
      case (k)
        0: v[14:10] = 5'h1F;
        1: v[14:10] = 5'h00;
        2: v[14:0]  = 15'h0;
        default: ;
      endcase
    end else begin
      case (k)
        0: v[30:23] = 8'hFF;
        1: v[30:23] = 8'h00;
        2: v[30:0]  = 31'h0;
        3: v[30:23] = 8'd120 + 8'($urandom_range(15));
        default: ;
      endcase
    end
    return v;
  endfunction

  initial begin
    int nz;
    logic f;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", pk_out(), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;

    // Directed cases, back-to-back, no backpressure.
    chk_lat = 1;
    add(1'b0, 32'h3F800000, 32'h3F000000, 1'b0);
    add(1'b0, 32'h3F000000, 32'hBF800000, 1'b0);
    add(1'b1, 32'h00007BFF, 32'h00000001, 1'b0);
    add(1'b0, 32'h7FC00000, 32'h12345678, 1'b0);
    add(1'b0, 32'h00000000, 32'h00000000, 1'b0);
    add(1'b0, 32'h3F800000, 32'h3F800000, 1'b1);
    add(1'b1, 32'hABCD3C00, 32'h0000BC00, 1'b1);
    inrdy_hist.delete();
    run(100, 100, 40);
    nz = 0;
    foreach (inrdy_hist[i]) if (!inrdy_hist[i]) nz++;
    check("full_rate_in_ready", 128'(nz), 128'd0);
    chk_lat = 0;

    // Backpressure: four beats, output stalled for three cycles.
    for (int i = 0; i < 4; i++) add(1'b0, rnd_op(1'b0), rnd_op(1'b0), 1'($urandom_range(1)));
    rdy_sched = '{1'b0, 1'b0, 1'b0};
    inrdy_hist.delete();
    run(100, 100, 40);
    check("bp_in_ready_c1", 128'(inrdy_hist[1]), 128'd1);
    check("bp_in_ready_c2", 128'(inrdy_hist[2]), 128'd0);
    check("bp_in_ready_c3", 128'(inrdy_hist[3]), 128'd1);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_fmt = 1'b0; in_a = rnd_op(1'b0); in_b = rnd_op(1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    nz = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nz++;
    end
    check("no_stale_after_rst", 128'(nz), 128'd0);

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      f = 1'($urandom_range(1));
      add(f, rnd_op(f), rnd_op(f), 1'($urandom_range(1)));
    end
    run(70, 70, 6000);
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
